// File: rtl/uart_rx_if.sv
// Receive-path bundle between the serial pin, the UART receiver and its byte consumer.
// master is the receiver side; slave is the line driver / byte consumer side.
`timescale 1ns/1ps

interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_error;
    logic       rx_busy;

    modport master (
        input  rx,
        output rx_data,
        output rx_done,
        output frame_error,
        output rx_busy
    );

    modport slave (
        output rx,
        input  rx_data,
        input  rx_done,
        input  frame_error,
        input  rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver: synchronised rx pin, start-bit validation, mid-bit sampling,
// one-cycle rx_done strobe with a stop-bit frame_error flag.
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic clk,
    input  logic rst_n,
    uart_rx_if.master bus
);

    localparam int          BAUD_CNT  = CLK_FREQ / BAUD;
    localparam int          HALF_CNT  = BAUD_CNT / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic        rx_meta_reg;
    logic        rx_s_reg;
    logic        rx_d_reg;

    logic [15:0] cnt_reg;
    logic [15:0] cnt_next;
    logic [2:0]  bit_idx_reg;
    logic [2:0]  bit_idx_next;
    logic [7:0]  shift_reg;
    logic [7:0]  shift_next;

    logic [7:0]  rx_data_reg;
    logic        rx_done_reg;
    logic        frame_error_reg;

    logic        fall_edge;
    logic        half_tick;
    logic        baud_tick;

    logic        bit_sample;
    logic        frame_end;
    logic        busy;

    // Synchroniser and history FFs idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_d_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= bus.rx;
            rx_s_reg    <= rx_meta_reg;
            rx_d_reg    <= rx_s_reg;
        end
    end

    assign fall_edge = rx_d_reg & ~rx_s_reg;
    assign half_tick = (cnt_reg == HALF_LAST);
    assign baud_tick = (cnt_reg == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (fall_edge) begin
                    state_next = START;
                end
            end
            START: begin
                // A high line at mid-start-bit was only a glitch.
                if (half_tick) begin
                    state_next = rx_s_reg ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_tick && (bit_idx_reg == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state_reg != IDLE);
        bit_sample = (state_reg == DATA) && baud_tick;
        frame_end  = (state_reg == STOP) && baud_tick;
    end

    // Counter restarts on every state change and on every data-bit boundary.
    always_comb begin
        cnt_next = cnt_reg + 16'd1;
        if ((state_reg == IDLE) || (state_next != state_reg) || bit_sample) begin
            cnt_next = 16'd0;
        end
    end

    always_comb begin
        bit_idx_next = bit_idx_reg;
        if ((state_reg == START) && (state_next == DATA)) begin
            bit_idx_next = 3'd0;
        end else if (bit_sample && (bit_idx_reg != 3'd7)) begin
            bit_idx_next = bit_idx_reg + 3'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_shift
            assign shift_next[gi] = (bit_sample && (bit_idx_reg == 3'(gi))) ? rx_s_reg
                                                                             : shift_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg         <= 16'd0;
            bit_idx_reg     <= 3'd0;
            shift_reg       <= 8'h00;
            rx_data_reg     <= 8'h00;
            rx_done_reg     <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            rx_done_reg <= frame_end;
            // Data is delivered even on a bad stop bit; consumers gate on frame_error.
            if (frame_end) begin
                rx_data_reg     <= shift_reg;
                frame_error_reg <= ~rx_s_reg;
            end
        end
    end

    assign bus.rx_data     = rx_data_reg;
    assign bus.rx_done     = rx_done_reg;
    assign bus.frame_error = frame_error_reg;
    assign bus.rx_busy     = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_CNT=10 / HALF_CNT=5: frame contents, rx_done timing,
// bad stop bit, glitch rejection, back-to-back frames and reset mid-frame.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int BIT_CLKS   = 10;
    // start driven at cycle s -> detect at s+2, done at s+2+5+9*10+1
    localparam int DONE_DELAY = 98;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    uart_rx_if u_if ();

    uart_rx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   dbl_done = 0;
    int   nd = 0;
    logic prev_done = 1'b0;
    int         done_cyc_q[$];
    logic [7:0] data_q[$];
    logic       fe_q[$];

    always @(negedge clk) begin
        if (u_if.rx_done) begin
            done_cnt = done_cnt + 1;
            done_cyc_q.push_back(cyc);
            data_q.push_back(u_if.rx_data);
            fe_q.push_back(u_if.frame_error);
            if (prev_done) dbl_done = dbl_done + 1;
        end
        prev_done = u_if.rx_done;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s 0x%0h", tag, got);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        u_if.rx = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_val);
    endtask

    task automatic expect_frame(input string tag, input int s, input logic [7:0] d, input logic fe);
        check({tag, "_count"}, done_cnt, nd + 1);
        if (done_cnt > nd) begin
            check({tag, "_cycle"}, done_cyc_q[nd], s + DONE_DELAY);
            check({tag, "_data"}, int'(data_q[nd]), int'(d));
            check({tag, "_ferr"}, int'(fe_q[nd]), int'(fe));
        end
        nd = done_cnt;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        u_if.rx = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", int'(u_if.rx_data), 0);
        check("rst_done", int'(u_if.rx_done), 0);
        check("rst_ferr", int'(u_if.frame_error), 0);
        check("rst_busy", int'(u_if.rx_busy), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // basic frames
        align();
        s = cyc;
        send_byte(8'h03, 1'b1);
        expect_frame("f03", s, 8'h03, 1'b0);
        repeat (5) @(posedge clk);
        align();
        s = cyc;
        send_byte(8'h55, 1'b1);
        expect_frame("f55", s, 8'h55, 1'b0);
        repeat (5) @(posedge clk);

        // bad stop bit, then line held low (break)
        align();
        s = cyc;
        send_byte(8'hA5, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        u_if.rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        expect_frame("fA5", s, 8'hA5, 1'b1);
        check("break_no_done", done_cnt, nd);
        check("break_ferr_held", int'(u_if.frame_error), 1);
        align();
        s = cyc;
        send_byte(8'h06, 1'b1);
        expect_frame("f06", s, 8'h06, 1'b0);
        check("f06_ferr_live", int'(u_if.frame_error), 0);
        repeat (5) @(posedge clk);

        // 3-clk glitch in idle
        align();
        u_if.rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        u_if.rx = 1'b1;
        @(negedge clk);
        check("glitch_busy", int'(u_if.rx_busy), 1);
        repeat (15) @(posedge clk);
        #1;
        check("glitch_idle", int'(u_if.rx_busy), 0);
        check("glitch_no_done", done_cnt, nd);
        check("glitch_data", int'(u_if.rx_data), 8'h06);

        // back-to-back frames, no idle gap
        align();
        s = cyc;
        send_byte(8'h04, 1'b1);
        expect_frame("f04", s, 8'h04, 1'b0);
        s = cyc;
        send_byte(8'h05, 1'b1);
        expect_frame("f05", s, 8'h05, 1'b0);
        repeat (5) @(posedge clk);

        // reset during bit 3 of 0xFF
        align();
        fork
            send_byte(8'hFF, 1'b1);
            begin
                repeat (45) @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check("mid_rst_data", int'(u_if.rx_data), 0);
                check("mid_rst_done", int'(u_if.rx_done), 0);
                check("mid_rst_ferr", int'(u_if.frame_error), 0);
                check("mid_rst_busy", int'(u_if.rx_busy), 0);
                repeat (10) @(posedge clk);
                #2;
                rst_n = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt, nd);
        check("mid_rst_idle", int'(u_if.rx_busy), 0);
        align();
        s = cyc;
        send_byte(8'h3C, 1'b1);
        expect_frame("f3C", s, 8'h3C, 1'b0);

        repeat (20) @(posedge clk);
        #1;
        check("single_cycle_done", dbl_done, 0);
        check("total_frames", done_cnt, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
